// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: register map, STATUS/CTRL bit positions,
// synchronizer lane indices and the serial-side state encoding.
package spi_target_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_FLAGS_LO = 4;
    localparam int ST_SELECTED = 7;

    localparam int CTRL_IRQ_RX   = 0;
    localparam int CTRL_IRQ_TX   = 1;
    localparam int CTRL_IRQ_FLAG = 2;

    // Sticky flag vector order matches STATUS[6:4]
    localparam int FLAG_RXOVR = 0;
    localparam int FLAG_TXUND = 1;
    localparam int FLAG_TXOVF = 2;

    localparam int SYNC_MOSI = 0;
    localparam int SYNC_SS_N = 1;
    localparam int SYNC_SCLK = 2;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_LOAD  = 2'd1,
        SPI_SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_target_sync_fifo.sv
// Small synchronous FIFO with a registered head word that is always valid when not empty
// (write-through bypass covers a push into an empty/draining FIFO).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             sysclock,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             do_push, do_pop;

    assign full        = (count_reg == FULL_CNT);
    assign empty       = (count_reg == '0);
    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;
    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign head        = head_reg;

    always_ff @(posedge sysclock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Next head is being written this very cycle when the FIFO is (becoming) empty
            head_reg <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with Wishbone classic register port; bytes flow between an external
// SPI master and software through an RX and a TX FIFO.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = 8'hff
) (
    input  logic        sysclock,
    input  logic        rst_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    input  logic        spi_sclk,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        miso_oe,
    output logic        irq
);
    logic [2:0] async_in, sync_cur, sync_prev;

    assign async_in[SYNC_MOSI] = spi_mosi;
    assign async_in[SYNC_SS_N] = spi_ss_n;
    assign async_in[SYNC_SCLK] = spi_sclk;

    // Stages 0/1 form the synchronizer; stage 2 is the history used for edge detection
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            localparam logic RST_VAL = (gi == SYNC_SS_N);
            logic [2:0] stage_reg;
            always_ff @(posedge sysclock or posedge rst_i) begin
                if (rst_i) begin
                    stage_reg <= {3{RST_VAL}};
                end else begin
                    stage_reg <= {stage_reg[1:0], async_in[gi]};
                end
            end
            assign sync_cur[gi]  = stage_reg[1];
            assign sync_prev[gi] = stage_reg[2];
        end
    endgenerate

    logic selected, ss_fall, sclk_rise, sclk_fall, mosi_bit;
    assign selected  = ~sync_cur[SYNC_SS_N];
    assign ss_fall   = ~sync_cur[SYNC_SS_N] & sync_prev[SYNC_SS_N];
    assign sclk_rise = sync_cur[SYNC_SCLK] & ~sync_prev[SYNC_SCLK];
    assign sclk_fall = ~sync_cur[SYNC_SCLK] & sync_prev[SYNC_SCLK];
    assign mosi_bit  = sync_prev[SYNC_MOSI];

    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] rx_byte, rx_head, tx_head;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .sysclock  (sysclock),
        .rst_i     (rst_i),
        .push      (rx_push),
        .push_data (rx_byte),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .sysclock  (sysclock),
        .rst_i     (rst_i),
        .push      (tx_push),
        .push_data (dat_i[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_state_t state_reg, state_next;
    logic [2:0] bitcnt_reg, bitcnt_next;
    logic [7:0] rx_shift_reg, rx_shift_next, tx_shift_reg, tx_shift_next;
    logic       txund_set;

    assign rx_byte = {rx_shift_reg[6:0], mosi_bit};

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= SPI_IDLE;
            bitcnt_reg   <= '0;
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
        end else begin
            state_reg    <= state_next;
            bitcnt_reg   <= bitcnt_next;
            rx_shift_reg <= rx_shift_next;
            tx_shift_reg <= tx_shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bitcnt_next   = bitcnt_reg;
        rx_shift_next = rx_shift_reg;
        tx_shift_next = tx_shift_reg;
        tx_pop        = 1'b0;
        rx_push       = 1'b0;
        txund_set     = 1'b0;
        case (state_reg)
            SPI_IDLE: begin
                tx_shift_next = '0;
                if (ss_fall) begin
                    state_next = SPI_LOAD;
                end
            end
            SPI_LOAD: begin
                bitcnt_next = '0;
                if (tx_empty) begin
                    tx_shift_next = FILL_BYTE;
                    txund_set     = 1'b1;
                end else begin
                    tx_shift_next = tx_head;
                    tx_pop        = 1'b1;
                end
                state_next = selected ? SPI_SHIFT : SPI_IDLE;
            end
            SPI_SHIFT: begin
                if (!selected) begin
                    state_next = SPI_IDLE;
                end else if (sclk_rise) begin
                    rx_shift_next = rx_byte;
                    bitcnt_next   = bitcnt_reg + 3'd1;
                    if (bitcnt_reg == 3'd7) begin
                        rx_push    = 1'b1;
                        state_next = SPI_LOAD;
                    end
                end else if (sclk_fall && (bitcnt_reg != 3'd0)) begin
                    tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                end
            end
            default: state_next = SPI_IDLE;
        endcase
    end

    assign spi_miso = selected & tx_shift_reg[7];
    assign miso_oe  = selected;

    // Bus side: ack once per strobe; all side effects keyed to the ack cycle
    logic       ack_reg, done_reg, irq_reg, bus_req, bus_rd, bus_wr;
    logic [2:0] ctrl_reg, flags_reg, flags_set, flags_clr, flags_next;
    logic [7:0] status;
    logic       irq_next;

    assign bus_req = cyc_i & stb_i;
    assign bus_rd  = ack_reg & ~we_i;
    assign bus_wr  = ack_reg & we_i & sel_i[0];
    assign rx_pop  = bus_rd & (adr_i == REG_DATA);
    assign tx_push = bus_wr & (adr_i == REG_DATA);

    assign flags_set[FLAG_RXOVR] = rx_push & rx_full;
    assign flags_set[FLAG_TXUND] = txund_set;
    assign flags_set[FLAG_TXOVF] = tx_push & tx_full;
    assign flags_clr  = (bus_wr && (adr_i == REG_STATUS)) ? dat_i[6:4] : 3'b000;
    assign flags_next = flags_set | (flags_reg & ~flags_clr);

    assign irq_next = (ctrl_reg[CTRL_IRQ_RX] & ~rx_empty)
                    | (ctrl_reg[CTRL_IRQ_TX] & tx_empty)
                    | (ctrl_reg[CTRL_IRQ_FLAG] & (|flags_reg));

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            ack_reg   <= 1'b0;
            done_reg  <= 1'b0;
            ctrl_reg  <= '0;
            flags_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            ack_reg   <= bus_req & ~ack_reg & ~done_reg;
            done_reg  <= bus_req & (ack_reg | done_reg);
            flags_reg <= flags_next;
            irq_reg   <= irq_next;
            if (bus_wr && (adr_i == REG_CTRL)) begin
                ctrl_reg <= dat_i[2:0];
            end
        end
    end

    always_comb begin
        status                   = '0;
        status[ST_RX_EMPTY]      = rx_empty;
        status[ST_RX_FULL]       = rx_full;
        status[ST_TX_EMPTY]      = tx_empty;
        status[ST_TX_FULL]       = tx_full;
        status[ST_FLAGS_LO+:3]   = flags_reg;
        status[ST_SELECTED]      = selected;
    end

    always_comb begin
        dat_o = '0;
        if (bus_rd) begin
            case (adr_i)
                REG_DATA:   dat_o = rx_empty ? 32'h0 : {24'h0, rx_head};
                REG_STATUS: dat_o = {24'h0, status};
                REG_CTRL:   dat_o = {29'h0, ctrl_reg};
                REG_RSVD:   dat_o = '0;
            endcase
        end
    end

    assign ack_o = ack_reg;
    assign irq   = irq_reg;

    logic unused_bits;
    assign unused_bits = ^{dat_i[31:8], sel_i[3:1]};

endmodule
